// File: rtl/uart_pkg.sv
// Definitions shared by both UART directions: FSM state codes and line levels.
package uart_pkg;

  localparam int STATE_W = 5;

  // One-hot state codes; anything else is treated as illegal and recovers to idle.
  localparam logic [STATE_W-1:0] ST_IDLE   = 5'b00001;
  localparam logic [STATE_W-1:0] ST_START  = 5'b00010;
  localparam logic [STATE_W-1:0] ST_DATA   = 5'b00100;
  localparam logic [STATE_W-1:0] ST_PARITY = 5'b01000;
  localparam logic [STATE_W-1:0] ST_STOP   = 5'b10000;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data shift register for the UART transmitter; shifts one bit out per enable.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  shift_en,
  output logic                  ser_bit,
  output logic                  done
);

  localparam int IDX_W = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (load) begin
      shift_d = load_data;
      idx_d   = '0;
    end else if (shift_en) begin
      shift_d = shift_q >> 1;
      idx_d   = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  // idx counts bits already handed to the line; done once every data bit is out.
  assign ser_bit = shift_q[0];
  assign done    = (idx_q == IDX_W'(DATA_WIDTH));

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit controller: latches a word on handshake and sends start, data
// LSB-first, optional parity and stop bits, each held for PRESCALE clocks.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int STOP_BITS      = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic                      TX_OUT,
  output logic                      busy
);

  localparam int PW = PRESCALE_WIDTH;

  logic [STATE_W-1:0] state_q, state_d;
  logic [PW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      ps_q, ps_d;
  logic               par_en_q, par_en_d;
  logic               par_q, par_d;
  logic [1:0]         stop_cnt_q, stop_cnt_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;

  logic load, shift_en, ser_bit, ser_done, bit_end;

  assign bit_end = (cnt_q == (ps_q - PW'(1)));

  always_comb begin
    state_d    = state_q;
    ps_d       = ps_q;
    par_en_d   = par_en_q;
    par_d      = par_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    load       = 1'b0;
    shift_en   = 1'b0;
    cnt_d      = bit_end ? '0 : cnt_q + PW'(1);

    case (state_q)
      ST_IDLE: begin
        tx_d       = STOP_BIT;
        busy_d     = 1'b0;
        cnt_d      = '0;
        stop_cnt_d = '0;
        if (DATA_VALID && !busy_q) begin
          load     = 1'b1;
          ps_d     = (PRESCALE == '0) ? PW'(1) : PRESCALE;
          par_en_d = PAR_EN;
          par_d    = (^P_DATA) ^ (PAR_TYP != PAR_EVEN);
          state_d  = ST_START;
          tx_d     = START_BIT;
          busy_d   = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          tx_d     = ser_bit;
          shift_en = 1'b1;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (!ser_done) begin
            tx_d     = ser_bit;
            shift_en = 1'b1;
          end else if (par_en_q) begin
            tx_d    = par_q;
            state_d = ST_PARITY;
          end else begin
            tx_d    = STOP_BIT;
            state_d = ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          tx_d    = STOP_BIT;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == 2'(STOP_BITS - 1)) begin
            stop_cnt_d = '0;
            busy_d     = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 2'd1;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tx_d       = STOP_BIT;
        busy_d     = 1'b0;
        cnt_d      = '0;
        stop_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ps_q       <= '0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      stop_cnt_q <= '0;
      tx_q       <= STOP_BIT;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ps_q       <= ps_d;
      par_en_q   <= par_en_d;
      par_q      <= par_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_data(P_DATA),
    .shift_en (shift_en),
    .ser_bit  (ser_bit),
    .done     (ser_done)
  );

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: two instances (one and two stop bits) checked against
// a frame-level reference model through a scoreboard queue.
module tb_uart_tx_fsm;

  localparam int DW = 8;
  localparam int PW = 6;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [DW-1:0] p_data;
  logic [1:0]    dv;
  logic          par_en, par_typ;
  logic [PW-1:0] prescale;
  logic [1:0]    tx_w, busy_w;

  uart_tx_fsm #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .P_DATA(p_data), .DATA_VALID(dv[0]), .PAR_EN(par_en),
    .PAR_TYP(par_typ), .PRESCALE(prescale), .TX_OUT(tx_w[0]), .busy(busy_w[0]));

  uart_tx_fsm #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .P_DATA(p_data), .DATA_VALID(dv[1]), .PAR_EN(par_en),
    .PAR_TYP(par_typ), .PRESCALE(prescale), .TX_OUT(tx_w[1]), .busy(busy_w[1]));

  int checks = 0;
  int errors = 0;

  // scoreboard: one entry per accepted frame
  logic [15:0] exp_q[2][$];
  int          len_q[2][$];
  int          psq_q[2][$];

  int rem[2]       = '{0, 0};
  int abort_cnt[2] = '{0, 0};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame bits in line order: start, data LSB-first, parity, then stop ones.
  function automatic logic [15:0] frame_of(input logic [DW-1:0] d, input logic pe,
                                           input logic pt);
    logic [15:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DW; i++) f[1+i] = d[i];
    if (pe) f[DW+1] = (^d) ^ pt;
    return f;
  endfunction

  // reference model: decides accept edges and frame contents
  initial begin
    int ps, n;
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          if (rem[d] > 0) abort_cnt[d]++;
          rem[d] = 0;
        end else if (rem[d] > 0) begin
          rem[d]--;
        end else if (dv[d]) begin
          ps = (prescale == '0) ? 1 : int'(prescale);
          n  = 1 + DW + int'(par_en) + (d + 1);
          exp_q[d].push_back(frame_of(p_data, par_en, par_typ));
          len_q[d].push_back(n * ps);
          psq_q[d].push_back(ps);
          rem[d] = n * ps;
        end
      end
    end
  end

  // monitor: captures each busy window and compares with the scoreboard
  logic        in_f[2]     = '{1'b0, 1'b0};
  logic        bad[2]      = '{1'b0, 1'b0};
  int          cyc[2]      = '{0, 0};
  int          bad_cyc[2]  = '{0, 0};
  int          abort_seen[2] = '{0, 0};
  logic [15:0] cur_f[2];
  int          cur_len[2];
  int          cur_ps[2];
  int          frames_ok   = 0;

  initial begin
    logic exp_bit;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!in_f[d] && busy_w[d] === 1'b1) begin
          in_f[d] = 1'b1;
          cyc[d]  = 0;
          bad[d]  = 1'b0;
          if (exp_q[d].size() == 0) begin
            check($sformatf("unexpected_frame_dut%0d", d), 1, 0);
            cur_f[d] = '1; cur_len[d] = 0; cur_ps[d] = 1;
          end else begin
            cur_f[d]   = exp_q[d].pop_front();
            cur_len[d] = len_q[d].pop_front();
            cur_ps[d]  = psq_q[d].pop_front();
          end
        end
        if (in_f[d]) begin
          if (busy_w[d] === 1'b1) begin
            exp_bit = (cyc[d] < cur_len[d]) ? cur_f[d][cyc[d] / cur_ps[d]] : 1'b1;
            if (tx_w[d] !== exp_bit && !bad[d]) begin
              bad[d]     = 1'b1;
              bad_cyc[d] = cyc[d];
            end
            cyc[d]++;
          end else begin
            in_f[d] = 1'b0;
            if (abort_cnt[d] > abort_seen[d]) begin
              abort_seen[d]++;
            end else begin
              check($sformatf("frame_bits_dut%0d first_bad_cycle", d),
                    bad[d] ? bad_cyc[d] : -1, -1);
              check($sformatf("frame_len_dut%0d", d), cyc[d], cur_len[d]);
              check($sformatf("idle_tx_dut%0d", d), int'(tx_w[d]), 1);
              frames_ok++;
            end
          end
        end
      end
    end
  end

  // driver tasks (all run in the posedge+1 phase)
  task automatic wait_idle(input int d);
    int n = 0;
    while (rem[d] != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (rem[d] != 0) check($sformatf("idle_timeout_dut%0d", d), rem[d], 0);
  endtask

  task automatic scramble();
    p_data   = DW'($urandom);
    par_en   = 1'($urandom_range(0, 1));
    par_typ  = 1'($urandom_range(0, 1));
    prescale = PW'($urandom_range(0, 63));
  endtask

  task automatic send(input int d, input logic [DW-1:0] data, input logic pe,
                      input logic pt, input logic [PW-1:0] ps);
    wait_idle(d);
    p_data   = data;
    par_en   = pe;
    par_typ  = pt;
    prescale = ps;
    dv[d]    = 1'b1;
    @(posedge clk); #1;
    dv[d] = 1'b0;
    scramble();
  endtask

  task automatic held_high(input int d, input int ncyc);
    wait_idle(d);
    dv[d] = 1'b1;
    repeat (ncyc) begin
      p_data   = DW'($urandom);
      par_en   = 1'($urandom_range(0, 1));
      par_typ  = 1'($urandom_range(0, 1));
      prescale = PW'($urandom_range(0, 2));
      @(posedge clk); #1;
    end
    dv[d] = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; dv = 2'b00; p_data = '0; par_en = 1'b0; par_typ = 1'b0; prescale = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_dut0", int'(tx_w[0]), 1);
    check("reset_busy_dut0", int'(busy_w[0]), 0);
    check("reset_tx_dut1", int'(tx_w[1]), 1);
    check("reset_busy_dut1", int'(busy_w[1]), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // directed frames
    send(0, 8'hA5, 1'b0, 1'b0, 6'd1);
    send(0, 8'hA5, 1'b1, 1'b0, 6'd1);
    send(0, 8'hA5, 1'b1, 1'b1, 6'd1);
    send(0, 8'h3C, 1'b1, 1'b0, 6'd16);

    // request held high with inputs changing every cycle
    held_high(0, 80);

    // reset in the fifth cycle of data bit 0 at PS=8
    send(0, 8'h5A, 1'b0, 1'b0, 6'd8);
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midframe_reset_tx", int'(tx_w[0]), 1);
    check("midframe_reset_busy", int'(busy_w[0]), 0);
    rst = 1'b0;
    send(0, 8'hC3, 1'b1, 1'b1, 6'd3);

    // randomized frames
    for (int i = 0; i < 20; i++)
      send(0, DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           PW'($urandom_range(0, 5)));

    // two stop bits, PRESCALE=0 treated as 1
    send(1, 8'hA5, 1'b0, 1'b0, 6'd0);
    for (int i = 0; i < 6; i++)
      send(1, DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           PW'($urandom_range(0, 4)));
    held_high(1, 40);

    wait_idle(0);
    wait_idle(1);
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q[0].size() + exp_q[1].size(), 0);
    check("frames_seen_min", int'(frames_ok >= 30), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fsm.md
Name: uart_tx_fsm

Overview:
- UART transmit controller, the transmit end of the serial link: accepts one parallel word per handshake and serialises it onto TX_OUT.
- Frame order: start bit (0), data LSB-first, optional parity, stop bit(s) (1).
- Bit timing comes from an internal prescale counter, so each bit is held for PRESCALE clk cycles.
- Sits in the UART block beside the receive path and shares its frame format and prescale convention.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESCALE_WIDTH, 6, width of the PRESCALE input.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
- clk  input  1  single clock; every register is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- P_DATA  input  DATA_WIDTH  parallel word to transmit.
- DATA_VALID  input  1  request; accepted only in a cycle where busy=0.
- PAR_EN  input  1  1 = parity bit inserted.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- PRESCALE  input  PRESCALE_WIDTH  clk cycles per bit; 0 is treated as 1.
- TX_OUT  output  1  serial line; registered; idles high.
- busy  output  1  registered; high while a frame is in flight.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: TX_OUT=1, busy=0, state IDLE, all counters 0.
  - rst asserted mid-frame aborts the frame; the cycle after the reset edge shows TX_OUT=1, busy=0.
  - No partial bit is completed.
- State machine: one-hot encoding, states IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, busy=0.
  - Accept = DATA_VALID and busy=0, sampled at clk edge N.
  - On accept, latch P_DATA, PAR_EN, PAR_TYP and PRESCALE (0 mapped to 1).
  - Compute the parity bit from the latched data: even = XOR of the data bits; odd = its inverse.
  - Go to START.
- Output timing: outputs are registered, so in cycle N+1 TX_OUT=0 (start bit) and busy=1.
- Bit timing:
  - A prescale counter runs 0..PS-1, where PS is the latched prescale.
  - A bit ends when the counter reaches PS-1; the counter then wraps to 0.
  - Every bit, including each stop bit, lasts exactly PS cycles.
- START: drive 0 for one bit, then go to DATA with bit index 0.
- DATA:
  - Drive data[bit index] and increment the index at each bit end.
  - After bit DATA_WIDTH-1, go to PARITY if the latched PAR_EN=1, else to STOP.
- PARITY: drive the latched parity bit for one bit, then go to STOP.
- STOP:
  - Drive 1 for STOP_BITS bits, then go to IDLE.
  - busy is 0 in the cycle after the last stop cycle.
- Frame length: (1 + DATA_WIDTH + PAR_EN + STOP_BITS) × PS cycles of busy=1.
  - Example: 8N1 at PS=1 gives 10 cycles; 8E1 at PS=16 gives 176 cycles.
- DATA_VALID while busy=1 is ignored: no queuing, no error. Input changes mid-frame have no effect because everything was latched at accept.
- Back-to-back requests:
  - A request held high is accepted in the first IDLE cycle after a frame.
  - Consecutive frames are therefore separated by exactly one idle-high cycle (TX_OUT=1, busy=0).
  - This gap is required; do not remove it.
- TX_OUT is driven only from a flop; no combinational path from any input to TX_OUT or busy.
- Illegal or unused state encodings recover to IDLE on the next edge with TX_OUT=1.

Decomposition:
- Shared package (uart_pkg), used by both UART directions:
  - state encodings IDLE/START/DATA/PARITY/STOP;
  - constants START_BIT=0, STOP_BIT=1, PAR_EVEN=0, PAR_ODD=1.
- Sub-module uart_tx_serializer:
  - owns the shift register, bit index and done flag;
  - enabled by the FSM at each bit end.
- Parity calculation and prescale counter stay in the top module.

Test Plan:
- Reset, then P_DATA=0xA5, PAR_EN=0, PRESCALE=1, one-cycle DATA_VALID -> TX_OUT sequence from N+1 is 0,1,0,1,0,0,1,0,1,1; busy high exactly 10 cycles; then TX_OUT=1, busy=0.
- Same data with PAR_EN=1: PAR_TYP=0 gives parity 0 (11-bit frame); PAR_TYP=1 gives parity 1 -> both frames checked bit-by-bit.
- PRESCALE=16, P_DATA=0x3C, even parity -> each bit stable for exactly 16 cycles; busy=1 for 176 cycles; sample each bit at counter=8.
- DATA_VALID held high with P_DATA changing every cycle -> each frame carries the value present at its accept edge; one idle-high cycle between frames; mid-frame requests ignored.
- rst pulsed in cycle 5 of a DATA bit at PS=8 -> next cycle TX_OUT=1, busy=0; a new request afterwards produces a clean full frame.
- STOP_BITS=2, PRESCALE=0 -> PS treated as 1; stop level lasts 2 cycles; busy=1 for 11 cycles (8N2).
